// File: rtl/aq_vlsu_trans_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aq_vlsu_trans_seq_pkg                                                      |
// | Shared SEW codes, sequencer state encodings and reorder control codes.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package aq_vlsu_trans_seq_pkg;

  localparam logic [1:0] C_SEW_BYTE  = 2'b00;
  localparam logic [1:0] C_SEW_HALF  = 2'b01;
  localparam logic [1:0] C_SEW_WORD  = 2'b10;
  localparam logic [1:0] C_SEW_DWORD = 2'b11;

  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_RUN  = 2'd1;
  localparam logic [1:0] C_ST_DONE = 2'd2;

  localparam logic [2:0] C_BYTE_NONE = 3'h0;
  localparam logic [2:0] C_BYTE_B_F2 = 3'h1;
  localparam logic [2:0] C_BYTE_B_F3 = 3'h2;
  localparam logic [2:0] C_BYTE_B_F4 = 3'h3;
  localparam logic [2:0] C_BYTE_H_F2 = 3'h4;

  localparam logic [3:0] C_MUX_P0    = 4'h0;
  localparam logic [3:0] C_MUX_ST_P1 = 4'h3;
  localparam logic [3:0] C_MUX_ST_P2 = 4'h6;
  localparam logic [3:0] C_MUX_LD_P1 = 4'h1;
  localparam logic [3:0] C_MUX_LD_P2 = 4'h2;

  typedef struct packed {
    logic       st;
    logic [1:0] nf;
    logic [1:0] sew;
  } trans_cmd_t;

endpackage
`default_nettype wire

// File: rtl/aq_vlsu_trans_dec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aq_vlsu_trans_dec                                                          |
// | Combinational decode of command fields and beat phase to reorder codes.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aq_vlsu_trans_dec
  import aq_vlsu_trans_seq_pkg::*;
(
  input  logic       st,
  input  logic [1:0] nf,
  input  logic [1:0] sew,
  input  logic [1:0] phase,
  output logic [2:0] byte_reorder,
  output logic [3:0] mux_reorder
);

  always_comb begin
    byte_reorder = C_BYTE_NONE;
    if (sew == C_SEW_BYTE) begin
      case (nf)
        2'd1:    byte_reorder = C_BYTE_B_F2;
        2'd2:    byte_reorder = C_BYTE_B_F3;
        2'd3:    byte_reorder = C_BYTE_B_F4;
        default: byte_reorder = C_BYTE_NONE;
      endcase
    end else if ((sew == C_SEW_HALF) && (nf == 2'd1) && st) begin
      // The load path only consumes the low reorder bits, so halfword loads stay unswizzled.
      byte_reorder = C_BYTE_H_F2;
    end
  end

  always_comb begin
    mux_reorder = C_MUX_P0;
    if (nf == 2'd2) begin
      case (phase)
        2'd1:    mux_reorder = st ? C_MUX_ST_P1 : C_MUX_LD_P1;
        2'd2:    mux_reorder = st ? C_MUX_ST_P2 : C_MUX_LD_P2;
        default: mux_reorder = C_MUX_P0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/aq_vlsu_trans_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aq_vlsu_trans_seq                                                          |
// | Per-beat sequencer driving transpose reorder controls for one command.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aq_vlsu_trans_seq
  import aq_vlsu_trans_seq_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic             cmd_st,
  input  logic [1:0]       cmd_nf,
  input  logic [1:0]       cmd_sew,
  input  logic [CNT_W-1:0] cmd_beats,
  input  logic             flush,
  output logic             beat_vld,
  input  logic             beat_rdy,
  output logic [2:0]       beat_byte_reorder,
  output logic [3:0]       beat_mux_reorder,
  output logic [CNT_W-1:0] beat_idx,
  output logic             beat_last,
  output logic             cmd_done,
  output logic             busy
);

  localparam logic [CNT_W-1:0] C_IDX_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_IDX_ZERO = '0;

  logic [1:0]       r_state;
  trans_cmd_t       r_cmd;
  logic [CNT_W-1:0] r_beats;
  logic [CNT_W-1:0] r_idx;
  logic [1:0]       r_phase;
  logic             r_beat_vld;
  logic             r_last;
  logic             r_done;
  logic [2:0]       r_byte;
  logic [3:0]       r_mux;

  logic             w_accept;
  logic             w_fire;
  logic             w_end;
  logic             w_step;
  logic [CNT_W-1:0] w_idx_nxt;
  logic [1:0]       w_phase_nxt;
  trans_cmd_t       w_dec_cmd;
  logic [1:0]       w_dec_phase;
  logic [2:0]       w_byte;
  logic [3:0]       w_mux;

  assign cmd_rdy     = (r_state == C_ST_IDLE) && !flush;
  assign w_accept    = cmd_vld && cmd_rdy;
  assign w_fire      = r_beat_vld && beat_rdy;
  assign w_end       = w_fire && (r_idx == r_beats);
  assign w_step      = w_fire && (r_idx != r_beats);
  assign w_idx_nxt   = r_idx + C_IDX_ONE;
  assign w_phase_nxt = (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;

  // Decode the values the controls will hold after this edge so they leave a register.
  assign w_dec_cmd   = w_accept ? trans_cmd_t'{st: cmd_st, nf: cmd_nf, sew: cmd_sew} : r_cmd;
  assign w_dec_phase = w_accept ? 2'd0 : w_phase_nxt;

  aq_vlsu_trans_dec u_dec (
    .st           (w_dec_cmd.st),
    .nf           (w_dec_cmd.nf),
    .sew          (w_dec_cmd.sew),
    .phase        (w_dec_phase),
    .byte_reorder (w_byte),
    .mux_reorder  (w_mux)
  );

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_state    <= C_ST_IDLE;
      r_cmd      <= '0;
      r_beats    <= '0;
      r_idx      <= '0;
      r_phase    <= 2'd0;
      r_beat_vld <= 1'b0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
      r_byte     <= C_BYTE_NONE;
      r_mux      <= C_MUX_P0;
    end else if (flush) begin
      r_state    <= C_ST_IDLE;
      r_idx      <= '0;
      r_phase    <= 2'd0;
      r_beat_vld <= 1'b0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
      r_byte     <= C_BYTE_NONE;
      r_mux      <= C_MUX_P0;
    end else begin
      case (r_state)
        C_ST_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state    <= C_ST_RUN;
            r_cmd      <= w_dec_cmd;
            r_beats    <= cmd_beats;
            r_idx      <= '0;
            r_phase    <= 2'd0;
            r_beat_vld <= 1'b1;
            r_last     <= (cmd_beats == C_IDX_ZERO);
            r_byte     <= w_byte;
            r_mux      <= w_mux;
          end
        end
        C_ST_RUN: begin
          if (w_end) begin
            r_state    <= C_ST_DONE;
            r_idx      <= '0;
            r_phase    <= 2'd0;
            r_beat_vld <= 1'b0;
            r_last     <= 1'b0;
            r_done     <= 1'b1;
            r_byte     <= C_BYTE_NONE;
            r_mux      <= C_MUX_P0;
          end else if (w_step) begin
            r_idx   <= w_idx_nxt;
            r_phase <= w_phase_nxt;
            r_last  <= (w_idx_nxt == r_beats);
            r_byte  <= w_byte;
            r_mux   <= w_mux;
          end
        end
        C_ST_DONE: begin
          r_state <= C_ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state    <= C_ST_IDLE;
          r_beat_vld <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign beat_vld          = r_beat_vld;
  assign beat_byte_reorder = r_byte;
  assign beat_mux_reorder  = r_mux;
  assign beat_idx          = r_idx;
  assign beat_last         = r_last;
  assign cmd_done          = r_done;
  assign busy              = (r_state != C_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aq_vlsu_trans_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aq_vlsu_trans_seq                                                       |
// | Directed scoreboard bench for the transpose beat sequencer.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_aq_vlsu_trans_seq;

  localparam int CNT_W = 5;

  logic             clk;
  logic             rst;
  logic             cmd_vld;
  logic             cmd_rdy;
  logic             cmd_st;
  logic [1:0]       cmd_nf;
  logic [1:0]       cmd_sew;
  logic [CNT_W-1:0] cmd_beats;
  logic             flush;
  logic             beat_vld;
  logic             beat_rdy;
  logic [2:0]       beat_byte_reorder;
  logic [3:0]       beat_mux_reorder;
  logic [CNT_W-1:0] beat_idx;
  logic             beat_last;
  logic             cmd_done;
  logic             busy;

  typedef struct packed {
    logic [2:0]       b;
    logic [3:0]       m;
    logic [CNT_W-1:0] idx;
    logic             last;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  aq_vlsu_trans_seq #(.CNT_W(CNT_W)) dut (
    .forever_cpuclk    (clk),
    .cpurst            (rst),
    .cmd_vld           (cmd_vld),
    .cmd_rdy           (cmd_rdy),
    .cmd_st            (cmd_st),
    .cmd_nf            (cmd_nf),
    .cmd_sew           (cmd_sew),
    .cmd_beats         (cmd_beats),
    .flush             (flush),
    .beat_vld          (beat_vld),
    .beat_rdy          (beat_rdy),
    .beat_byte_reorder (beat_byte_reorder),
    .beat_mux_reorder  (beat_mux_reorder),
    .beat_idx          (beat_idx),
    .beat_last         (beat_last),
    .cmd_done          (cmd_done),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed=timeout expected=finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] m_byte(input logic st, input logic [1:0] nf, input logic [1:0] sew);
    if (sew == 2'b00 && nf == 2'd1) return 3'h1;
    if (sew == 2'b00 && nf == 2'd2) return 3'h2;
    if (sew == 2'b00 && nf == 2'd3) return 3'h3;
    if (sew == 2'b01 && nf == 2'd1 && st) return 3'h4;
    return 3'h0;
  endfunction

  function automatic logic [3:0] m_mux(input logic st, input logic [1:0] nf, input int i);
    int p;
    p = i % 3;
    if (nf != 2'd2) return 4'h0;
    return st ? 4'(3 * p) : 4'(p);
  endfunction

  task automatic check_idle_reset(input string tag);
    chk({tag, "_cmd_rdy"}, cmd_rdy, 1);
    chk({tag, "_beat_vld"}, beat_vld, 0);
    chk({tag, "_byte"}, beat_byte_reorder, 0);
    chk({tag, "_mux"}, beat_mux_reorder, 0);
    chk({tag, "_idx"}, beat_idx, 0);
    chk({tag, "_last"}, beat_last, 0);
    chk({tag, "_done"}, cmd_done, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic issue(input logic st, input logic [1:0] nf, input logic [1:0] sew,
                       input logic [CNT_W-1:0] beats);
    beat_t e;
    chk("issue_cmd_rdy", cmd_rdy, 1);
    cmd_vld = 1'b1; cmd_st = st; cmd_nf = nf; cmd_sew = sew; cmd_beats = beats;
    for (int i = 0; i <= int'(beats); i++) begin
      e.b    = m_byte(st, nf, sew);
      e.m    = m_mux(st, nf, i);
      e.idx  = CNT_W'(i);
      e.last = (i == int'(beats));
      exp_q.push_back(e);
    end
    step();
    cmd_vld = 1'b0;
    chk("issue_busy", busy, 1);
    chk("issue_cmd_rdy_run", cmd_rdy, 0);
  endtask

  task automatic consume(input int stall_at, input int stall_n, input int flush_at);
    int    budget;
    int    stalls;
    bit    flushed;
    beat_t e;
    budget  = 200;
    stalls  = stall_n;
    flushed = 1'b0;
    while (exp_q.size() > 0 && budget > 0) begin
      budget--;
      e = exp_q[0];
      chk("beat_vld", beat_vld, 1);
      chk("beat_idx", beat_idx, e.idx);
      chk("beat_byte", beat_byte_reorder, e.b);
      chk("beat_mux", beat_mux_reorder, e.m);
      chk("beat_last", beat_last, e.last);
      if (int'(e.idx) == stall_at && stalls > 0) begin
        beat_rdy = 1'b0;
        stalls--;
      end else begin
        beat_rdy = 1'b1;
        void'(exp_q.pop_front());
        if (int'(e.idx) == flush_at) begin
          flush   = 1'b1;
          flushed = 1'b1;
          exp_q.delete();
        end
      end
      step();
    end
    beat_rdy = 1'b0;
    if (exp_q.size() > 0) begin
      chk("beat_budget_left", exp_q.size(), 0);
      exp_q.delete();
    end
    if (flushed) begin
      flush = 1'b0;
      #1;
      chk("flush_beat_vld", beat_vld, 0);
      chk("flush_no_done", cmd_done, 0);
      chk("flush_busy", busy, 0);
      chk("flush_cmd_rdy", cmd_rdy, 1);
      step();
      chk("flush_no_done_late", cmd_done, 0);
    end else begin
      chk("done_pulse", cmd_done, 1);
      chk("done_beat_vld", beat_vld, 0);
      chk("done_busy", busy, 1);
      chk("done_cmd_rdy", cmd_rdy, 0);
      step();
      chk("done_pulse_end", cmd_done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_cmd_rdy", cmd_rdy, 1);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_vld = 1'b0; cmd_st = 1'b0; cmd_nf = 2'd0; cmd_sew = 2'd0;
    cmd_beats = '0; flush = 1'b0; beat_rdy = 1'b0;
    step(); step();
    check_idle_reset("reset");
    rst = 1'b0;
    step();

    // load, 3 fields, byte: rotating load mux codes
    issue(1'b0, 2'd2, 2'b00, 5'd5);
    consume(-1, 0, -1);

    // store, 3 fields, half: rotating store mux codes, no byte swizzle
    issue(1'b1, 2'd2, 2'b01, 5'd2);
    consume(-1, 0, -1);

    // store, 2 fields, half
    issue(1'b1, 2'd1, 2'b01, 5'd1);
    consume(-1, 0, -1);

    // load, 2 fields, half: byte code suppressed on the load path
    issue(1'b0, 2'd1, 2'b01, 5'd1);
    consume(-1, 0, -1);

    // backpressure at idx1 for 3 cycles
    issue(1'b0, 2'd2, 2'b00, 5'd4);
    consume(1, 3, -1);

    // flush together with beat_rdy at idx2, then a fresh command
    issue(1'b1, 2'd2, 2'b00, 5'd7);
    consume(-1, 0, 2);
    issue(1'b0, 2'd3, 2'b00, 5'd2);
    consume(-1, 0, -1);

    // single-beat command
    issue(1'b0, 2'd0, 2'b10, 5'd0);
    consume(-1, 0, -1);

    // maximum-length command
    issue(1'b0, 2'd3, 2'b00, 5'd31);
    consume(-1, 0, -1);

    // flush wins over cmd_vld in IDLE
    cmd_vld = 1'b1; cmd_st = 1'b0; cmd_nf = 2'd2; cmd_sew = 2'b00; cmd_beats = 5'd3;
    flush = 1'b1;
    #1;
    chk("flush_idle_cmd_rdy", cmd_rdy, 0);
    step();
    chk("flush_idle_busy", busy, 0);
    chk("flush_idle_beat_vld", beat_vld, 0);
    cmd_vld = 1'b0; flush = 1'b0;
    #1;
    chk("flush_idle_rdy_after", cmd_rdy, 1);
    step();

    // async reset mid-command
    issue(1'b1, 2'd2, 2'b00, 5'd9);
    beat_rdy = 1'b1;
    step(); step();
    #2;
    rst = 1'b1;
    #1;
    check_idle_reset("async_rst");
    exp_q.delete();
    beat_rdy = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("rst_release_cmd_rdy", cmd_rdy, 1);
    step();
    issue(1'b0, 2'd2, 2'b00, 5'd2);
    consume(-1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
